rf_window_streamer: RTL

RF_WINDOW_STREAMER -- requirements
Module: rf_window_streamer

---
 rtl/rf_window_streamer_if.sv | 24 ++
 rtl/rf_window_streamer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/rf_window_streamer_if.sv
// Window stream bundle: valid/ready handshake carrying a wide
// window payload plus a last-of-job marker.
interface rf_window_streamer_if #(
  parameter int W = 96
) ();
  logic         win_valid_o;
  logic         win_ready_i;
  logic [W-1:0] win_data_o;
  logic         win_last_o;

  modport master (
    output win_valid_o,
    output win_data_o,
    output win_last_o,
    input  win_ready_i
  );

  modport slave (
    input  win_valid_o,
    input  win_data_o,
    input  win_last_o,
    output win_ready_i
  );
endinterface

// File: rtl/rf_window_streamer.sv
// Streams count strided wide register-file reads out as windows.
// Ports: clk/rst_n, job control (start/base/stride/count/clear,
// busy/done), RF read (ren/raddr/rdata), window stream (win).
module rf_window_streamer #(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int ASYMM_FACTOR = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  input  logic [ADDR_WIDTH:0]   count_i,
  input  logic                 clear_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 rf_ren_o,
  output logic [ADDR_WIDTH-1:0] rf_raddr_o,
  input  logic [ASYMM_FACTOR*DATA_WIDTH-1:0] rf_rdata_i,
  rf_window_streamer_if.master win
);

  localparam int AW = ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  localparam int WW = ASYMM_FACTOR * DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   stride_q, stride_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   issued_q, issued_d;
  logic [CW-1:0]   taken_q, taken_d;
  logic            infl_q, infl_d;
  logic [WW-1:0]   mem_q [2];
  logic [WW-1:0]   mem_d [2];
  logic            wptr_q, wptr_d;
  logic            rptr_q, rptr_d;
  logic [1:0]      occ_q, occ_d;

  logic            valid;
  logic            pop;
  logic            push;
  logic            last;
  logic            ren;
  logic [2:0]      pend;

  assign valid = (occ_q != 2'd0);
  assign pop   = valid && win.win_ready_i;
  assign push  = infl_q;
  assign last  = (taken_q == count_q - CW'(1));

  // A slot vacated by this cycle's pop counts as free, which is
  // what lets a ready sink take one window every cycle.
  assign pend  = 3'(occ_q) + 3'(infl_q) - 3'(pop);
  assign ren   = (state_q == RUN)
              && (issued_q < count_q)
              && (pend < 3'd2);

  assign rf_ren_o       = ren;
  assign rf_raddr_o     = ren ? addr_q : '0;
  assign busy_o         = (state_q == RUN);
  assign done_o         = (state_q == DONE);
  assign win.win_valid_o = valid;
  assign win.win_data_o  = mem_q[rptr_q];
  assign win.win_last_o  = valid && last;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    count_d  = count_q;
    issued_d = issued_q;
    taken_d  = taken_q;
    infl_d   = infl_q;
    mem_d    = mem_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    occ_d    = occ_q;

    if (clear_i) begin
      state_d  = IDLE;
      issued_d = '0;
      taken_d  = '0;
      infl_d   = 1'b0;
      wptr_d   = 1'b0;
      rptr_d   = 1'b0;
      occ_d    = 2'd0;
    end else begin
      infl_d = ren;
      if (ren) begin
        addr_d   = addr_q + stride_q;
        issued_d = issued_q + CW'(1);
      end
      if (push) begin
        mem_d[wptr_q] = rf_rdata_i;
        wptr_d        = ~wptr_q;
      end
      if (pop) begin
        rptr_d  = ~rptr_q;
        taken_d = taken_q + CW'(1);
      end
      occ_d = occ_q + 2'(push) - 2'(pop);

      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_d   = base_addr_i;
            stride_d = stride_i;
            count_d  = count_i;
            issued_d = '0;
            taken_d  = '0;
            state_d  = (count_i == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (pop && last) state_d = DONE;
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      count_q  <= '0;
      issued_q <= '0;
      taken_q  <= '0;
      infl_q   <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      count_q  <= count_d;
      issued_q <= issued_d;
      taken_q  <= taken_d;
      infl_q   <= infl_d;
      mem_q    <= mem_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule
